// File: rtl/rc4_task_sequencer.sv
// Top-level sequencer for the RC4 key search.
// It walks each candidate key through the init, shuffle and decode engines, then checks the result.
module rc4_task_sequencer #(
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 init_done,
    input  logic                 shuffle_done,
    input  logic                 decode_done,
    input  logic                 decode_valid,
    output logic                 init_start,
    output logic                 shuffle_start,
    output logic                 decode_start,
    output logic [1:0]           select_task,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 busy,
    output logic                 key_found,
    output logic                 key_fail
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT_GO   = 4'd1,
        S_INIT_WAIT = 4'd2,
        S_SHUF_GO   = 4'd3,
        S_SHUF_WAIT = 4'd4,
        S_DEC_GO    = 4'd5,
        S_DEC_WAIT  = 4'd6,
        S_CHECK     = 4'd7,
        S_FOUND     = 4'd8,
        S_FAIL      = 4'd9
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [KEY_WIDTH-1:0] r_key;
    logic [KEY_WIDTH-1:0] w_key_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic [1:0]           w_select;

    // State, key-under-test and latched plaintext verdict registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_key   <= {KEY_WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state, key advance and verdict latch
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_valid_nxt = r_valid;
        case (r_state)
            S_IDLE, S_FOUND, S_FAIL: begin
                if (start) begin
                    w_state_nxt = S_INIT_GO;
                    w_key_nxt   = {KEY_WIDTH{1'b0}};
                    w_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_INIT_GO: w_state_nxt = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (init_done) begin
                    w_state_nxt = S_SHUF_GO;
                end else begin
                    w_state_nxt = S_INIT_WAIT;
                end
            end
            S_SHUF_GO: w_state_nxt = S_SHUF_WAIT;
            S_SHUF_WAIT: begin
                if (shuffle_done) begin
                    w_state_nxt = S_DEC_GO;
                end else begin
                    w_state_nxt = S_SHUF_WAIT;
                end
            end
            S_DEC_GO: w_state_nxt = S_DEC_WAIT;
            S_DEC_WAIT: begin
                if (decode_done) begin
                    w_state_nxt = S_CHECK;
                    w_valid_nxt = decode_valid;
                end else begin
                    w_state_nxt = S_DEC_WAIT;
                end
            end
            S_CHECK: begin
                // The key is frozen at KEY_MAX on failure, so it never wraps to zero
                if (r_valid) begin
                    w_state_nxt = S_FOUND;
                end else if (r_key == KEY_MAX) begin
                    w_state_nxt = S_FAIL;
                end else begin
                    w_key_nxt   = r_key + {{(KEY_WIDTH-1){1'b0}}, 1'b1};
                    w_state_nxt = S_INIT_GO;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // S-memory owner decoded from the state register
    always_comb begin
        w_select = 2'b00;
        case (r_state)
            S_INIT_GO, S_INIT_WAIT: w_select = 2'b01;
            S_SHUF_GO, S_SHUF_WAIT: w_select = 2'b10;
            S_DEC_GO,  S_DEC_WAIT:  w_select = 2'b11;
            default:                w_select = 2'b00;
        endcase
    end

    assign select_task   = w_select;
    assign init_start    = (r_state == S_INIT_GO);
    assign shuffle_start = (r_state == S_SHUF_GO);
    assign decode_start  = (r_state == S_DEC_GO);
    assign secret_key    = r_key;
    assign key_found     = (r_state == S_FOUND);
    assign key_fail      = (r_state == S_FAIL);
    assign busy          = (r_state != S_IDLE) && (r_state != S_FOUND) && (r_state != S_FAIL);

endmodule
